// File: rtl/ozdefs_pkg.sv
// ozdefs: shared symbol constants, framing FSM states and captured header
// fields for the per-lane TS1/TS2 ordered-set detector.
package ozdefs;

  localparam logic [7:0] COM    = 8'hBC;  // K28.5, k=1
  localparam logic [7:0] PAD    = 8'hF7;  // K23.7, k=1
  localparam logic [7:0] TS1_ID = 8'h4A;  // D10.2, k=0
  localparam logic [7:0] TS2_ID = 8'h45;  // D5.2,  k=0

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR  = 2'd1,
    ID   = 2'd2,
    DONE = 2'd3
  } os_fsm_e;

  typedef struct packed {
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] ctrl;
    logic       link_pad;
    logic       lane_pad;
  } ts_fields_t;

endpackage

// File: rtl/ts_match_ctr.sv
// ts_match_ctr: consecutive identical-set counters for TS1 and TS2.
//   clk, reset          : clock, asynchronous active-high reset
//   clr                 : clears both counters and the previous-set record
//   done                : a well-formed set completed this cycle
//   is_ts2, link, lane,
//   link_pad, lane_pad  : identity of the completed set
//   ts1_cnt, ts2_cnt    : saturating consecutive-match counts
//   ts1_done, ts2_done  : count has reached NTS
module ts_match_ctr
  import ozdefs::*;
#(
  parameter int NTS = 1024,
  parameter int CW  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          done,
  input  logic          is_ts2,
  input  logic [7:0]    link,
  input  logic [7:0]    lane,
  input  logic          link_pad,
  input  logic          lane_pad,
  output logic [CW-1:0] ts1_cnt,
  output logic [CW-1:0] ts2_cnt,
  output logic          ts1_done,
  output logic          ts2_done
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic       prev_vld;
  logic       prev_ts2;
  logic [7:0] prev_link;
  logic [7:0] prev_lane;
  logic       prev_link_pad;
  logic       prev_lane_pad;
  logic       match;

  // Only the fields that identify the link/lane assignment take part in the
  // compare; nfts/rate/ctrl may differ between otherwise identical sets.
  assign match = prev_vld && (prev_ts2 == is_ts2) &&
                 (prev_link == link) && (prev_lane == lane) &&
                 (prev_link_pad == link_pad) && (prev_lane_pad == lane_pad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts1_cnt       <= '0;
      ts2_cnt       <= '0;
      prev_vld      <= 1'b0;
      prev_ts2      <= 1'b0;
      prev_link     <= '0;
      prev_lane     <= '0;
      prev_link_pad <= 1'b0;
      prev_lane_pad <= 1'b0;
    end else if (clr) begin
      // Clear has priority over a completing set.
      ts1_cnt  <= '0;
      ts2_cnt  <= '0;
      prev_vld <= 1'b0;
    end else if (done) begin
      prev_vld      <= 1'b1;
      prev_ts2      <= is_ts2;
      prev_link     <= link;
      prev_lane     <= lane;
      prev_link_pad <= link_pad;
      prev_lane_pad <= lane_pad;
      if (is_ts2) begin
        ts2_cnt <= match ? sat_inc(ts2_cnt) : CW'(1);
        ts1_cnt <= '0;
      end else begin
        ts1_cnt <= match ? sat_inc(ts1_cnt) : CW'(1);
        ts2_cnt <= '0;
      end
    end
  end

  assign ts1_done = (ts1_cnt >= CW'(NTS));
  assign ts2_done = (ts2_cnt >= CW'(NTS));

endmodule

// File: rtl/ts_os_detector.sv
// ts_os_detector: per-lane receive-side TS1/TS2 ordered-set framer.
//   clk, reset      : symbol clock, asynchronous active-high reset
//   en_n            : lane electrical idle; aborts framing, clears counters
//   clr_cnt         : synchronous counter clear from the LTSSM
//   rxdata/rxdatak  : received symbol and K flag
//   rxvalid         : symbol qualifier; unqualified symbols are ignored
//   os_valid        : one-cycle pulse per complete well-formed set
//   os_is_ts2, os_link(_pad), os_lane(_pad), os_nfts, os_rate, os_ctrl
//                   : fields of the last completed set
//   ts1_cnt/ts2_cnt : consecutive identical-set counts
//   ts1_done/ts2_done : counts have reached NTS
//   sym_err         : one-cycle pulse on a framing violation
module ts_os_detector
  import ozdefs::*;
#(
  parameter int NTS = 1024,
  parameter int CW  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_n,
  input  logic          clr_cnt,
  input  logic [7:0]    rxdata,
  input  logic          rxdatak,
  input  logic          rxvalid,
  output logic          os_valid,
  output logic          os_is_ts2,
  output logic [7:0]    os_link,
  output logic          os_link_pad,
  output logic [7:0]    os_lane,
  output logic          os_lane_pad,
  output logic [7:0]    os_nfts,
  output logic [7:0]    os_rate,
  output logic [7:0]    os_ctrl,
  output logic [CW-1:0] ts1_cnt,
  output logic [CW-1:0] ts2_cnt,
  output logic          ts1_done,
  output logic          ts2_done,
  output logic          sym_err
);

  os_fsm_e    state, state_n;
  logic [3:0] idx, idx_n;
  logic       err_n;
  logic       done_n;
  logic       cap_en;
  logic       type_en;
  logic       type_val;
  logic       is_com;
  logic [7:0] id_sym;

  ts_fields_t shadow;
  logic       shadow_ts2;
  ts_fields_t os_f;

  assign is_com = rxdatak && (rxdata == COM);
  assign id_sym = shadow_ts2 ? TS2_ID : TS1_ID;

  // Framing state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    err_n    = 1'b0;
    done_n   = 1'b0;
    cap_en   = 1'b0;
    type_en  = 1'b0;
    type_val = 1'b0;
    if (en_n) begin
      state_n = HUNT;
      idx_n   = '0;
    end else if (!rxvalid) begin
      // DONE lasts exactly one cycle even when no symbol is offered.
      if (state == DONE) state_n = HUNT;
    end else begin
      case (state)
        HUNT, DONE: begin
          // DONE behaves like HUNT so back-to-back sets need no gap.
          if (is_com) begin
            state_n = HDR;
            idx_n   = 4'd1;
          end else begin
            state_n = HUNT;
            idx_n   = '0;
          end
        end
        HDR: begin
          if (is_com) begin
            err_n   = 1'b1;
            state_n = HDR;
            idx_n   = 4'd1;
          end else if (rxdatak && ((idx > 4'd2) || (rxdata != PAD))) begin
            err_n   = 1'b1;
            state_n = HUNT;
            idx_n   = '0;
          end else begin
            cap_en = 1'b1;
            if (idx == 4'd5) begin
              state_n = ID;
              idx_n   = 4'd6;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
        end
        ID: begin
          if (is_com) begin
            err_n   = 1'b1;
            state_n = HDR;
            idx_n   = 4'd1;
          end else if (idx == 4'd6) begin
            if (!rxdatak && (rxdata == TS1_ID)) begin
              type_en  = 1'b1;
              type_val = 1'b0;
              idx_n    = 4'd7;
            end else if (!rxdatak && (rxdata == TS2_ID)) begin
              type_en  = 1'b1;
              type_val = 1'b1;
              idx_n    = 4'd7;
            end else begin
              err_n   = 1'b1;
              state_n = HUNT;
              idx_n   = '0;
            end
          end else if (rxdatak || (rxdata != id_sym)) begin
            err_n   = 1'b1;
            state_n = HUNT;
            idx_n   = '0;
          end else if (idx == 4'd15) begin
            state_n = DONE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Shadow capture and published fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      shadow_ts2 <= 1'b0;
      os_f       <= '0;
      os_is_ts2  <= 1'b0;
      sym_err    <= 1'b0;
    end else begin
      if (cap_en) begin
        // In HDR a K symbol only gets this far if it is PAD.
        case (idx)
          4'd1: begin
            shadow.link     <= rxdata;
            shadow.link_pad <= rxdatak;
          end
          4'd2: begin
            shadow.lane     <= rxdata;
            shadow.lane_pad <= rxdatak;
          end
          4'd3:    shadow.nfts <= rxdata;
          4'd4:    shadow.rate <= rxdata;
          4'd5:    shadow.ctrl <= rxdata;
          default: ;
        endcase
      end
      if (type_en) shadow_ts2 <= type_val;
      if (done_n) begin
        os_f      <= shadow;
        os_is_ts2 <= shadow_ts2;
      end
      sym_err <= err_n;
    end
  end

  assign os_valid    = (state == DONE);
  assign os_link     = os_f.link;
  assign os_link_pad = os_f.link_pad;
  assign os_lane     = os_f.lane;
  assign os_lane_pad = os_f.lane_pad;
  assign os_nfts     = os_f.nfts;
  assign os_rate     = os_f.rate;
  assign os_ctrl     = os_f.ctrl;

  ts_match_ctr #(
    .NTS(NTS),
    .CW (CW)
  ) u_match (
    .clk     (clk),
    .reset   (reset),
    .clr     (en_n | clr_cnt | err_n),
    .done    (done_n),
    .is_ts2  (shadow_ts2),
    .link    (shadow.link),
    .lane    (shadow.lane),
    .link_pad(shadow.link_pad),
    .lane_pad(shadow.lane_pad),
    .ts1_cnt (ts1_cnt),
    .ts2_cnt (ts2_cnt),
    .ts1_done(ts1_done),
    .ts2_done(ts2_done)
  );

endmodule

// File: tb/tb_ts_os_detector.sv
// Testbench for ts_os_detector: directed and randomized ordered-set traffic,
// a set-level reference model, and a scoreboard monitor on os_valid/sym_err.
module tb_ts_os_detector;
  import ozdefs::*;

  localparam int NTS  = 1024;
  localparam int CW   = 11;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_n;
  logic          clr_cnt;
  logic [7:0]    rxdata;
  logic          rxdatak;
  logic          rxvalid;
  logic          os_valid;
  logic          os_is_ts2;
  logic [7:0]    os_link;
  logic          os_link_pad;
  logic [7:0]    os_lane;
  logic          os_lane_pad;
  logic [7:0]    os_nfts;
  logic [7:0]    os_rate;
  logic [7:0]    os_ctrl;
  logic [CW-1:0] ts1_cnt;
  logic [CW-1:0] ts2_cnt;
  logic          ts1_done;
  logic          ts2_done;
  logic          sym_err;

  always #5 clk = ~clk;

  ts_os_detector #(.NTS(NTS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .en_n(en_n), .clr_cnt(clr_cnt),
    .rxdata(rxdata), .rxdatak(rxdatak), .rxvalid(rxvalid),
    .os_valid(os_valid), .os_is_ts2(os_is_ts2),
    .os_link(os_link), .os_link_pad(os_link_pad),
    .os_lane(os_lane), .os_lane_pad(os_lane_pad),
    .os_nfts(os_nfts), .os_rate(os_rate), .os_ctrl(os_ctrl),
    .ts1_cnt(ts1_cnt), .ts2_cnt(ts2_cnt),
    .ts1_done(ts1_done), .ts2_done(ts2_done), .sym_err(sym_err)
  );

  typedef struct {
    bit         ts2;
    logic [7:0] link, lane, nfts, rate, ctrl;
    bit         lpad, npad;
  } set_t;

  typedef struct {
    set_t s;
    int   c1, c2;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   vld_cyc[$];
  int   err_pushed = 0;
  int   err_seen   = 0;
  exp_t mon_e;

  // Set-level reference model state
  bit   m_prev_vld = 0;
  set_t m_prev;
  int   m1 = 0, m2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic set_t mk(input bit ts2, input logic [7:0] link, input bit lpad,
                              input logic [7:0] lane, input bit npad);
    set_t s;
    s.ts2 = ts2; s.link = lpad ? PAD : link; s.lpad = lpad;
    s.lane = npad ? PAD : lane; s.npad = npad;
    s.nfts = 8'($urandom_range(255)); s.rate = 8'($urandom_range(255));
    s.ctrl = 8'($urandom_range(255));
    return s;
  endfunction

  function automatic set_t rnd_set();
    int   r;
    logic [7:0] l, n;
    bit   lp, np;
    r = $urandom_range(3);
    lp = (r == 0); l = (r == 1) ? 8'h00 : (r == 2) ? 8'h01 : 8'hF7;
    r = $urandom_range(3);
    np = (r == 0); n = (r == 1) ? 8'h00 : (r == 2) ? 8'h05 : 8'hF7;
    return mk($urandom_range(9) < 3, l, lp, n, np);
  endfunction

  function automatic void sym_of(input set_t s, input int i, output logic [7:0] d, output logic k);
    case (i)
      0:       begin d = COM;    k = 1'b1;   end
      1:       begin d = s.link; k = s.lpad; end
      2:       begin d = s.lane; k = s.npad; end
      3:       begin d = s.nfts; k = 1'b0;   end
      4:       begin d = s.rate; k = 1'b0;   end
      5:       begin d = s.ctrl; k = 1'b0;   end
      default: begin d = s.ts2 ? TS2_ID : TS1_ID; k = 1'b0; end
    endcase
  endfunction

  // A symbol that violates the framing rules at position i (never COM).
  function automatic void bad_sym(input set_t s, input int i, output logic [7:0] d, output logic k);
    logic [7:0] id;
    id = s.ts2 ? TS2_ID : TS1_ID;
    if (i <= 2) begin d = 8'h1C; k = 1'b1; end
    else if (i <= 5) begin d = 8'hFB; k = 1'b1; end
    else if ($urandom_range(1) == 0) begin d = id; k = 1'b1; end
    else begin
      d = 8'($urandom_range(255));
      if (d == TS1_ID || d == TS2_ID || d == id) d = 8'h00;
      k = 1'b0;
    end
  endfunction

  function automatic void model_clear();
    m1 = 0; m2 = 0; m_prev_vld = 0;
  endfunction

  function automatic void model_err();
    model_clear();
    err_pushed++;
  endfunction

  function automatic void model_done(input set_t s, input bit clr);
    exp_t e;
    bit   same;
    if (clr) model_clear();
    else begin
      same = m_prev_vld && m_prev.ts2 == s.ts2 && m_prev.link == s.link &&
             m_prev.lane == s.lane && m_prev.lpad == s.lpad && m_prev.npad == s.npad;
      if (s.ts2) begin m2 = same ? ((m2 < CMAX) ? m2 + 1 : m2) : 1; m1 = 0; end
      else       begin m1 = same ? ((m1 < CMAX) ? m1 + 1 : m1) : 1; m2 = 0; end
      m_prev_vld = 1; m_prev = s;
    end
    e.s = s; e.c1 = m1; e.c2 = m2;
    exp_q.push_back(e);
  endfunction

  task automatic send_sym(input logic [7:0] d, input logic k, input bit clr);
    rxdata = d; rxdatak = k; rxvalid = 1'b1; clr_cnt = clr;
    @(posedge clk); #1;
    rxvalid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      rxvalid = 1'b0; rxdata = 8'($urandom_range(255)); rxdatak = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_part(input set_t s, input int from, input int to);
    logic [7:0] d; logic k;
    for (int i = from; i <= to; i++) begin
      sym_of(s, i, d, k);
      send_sym(d, k, 1'b0);
    end
  endtask

  // bad: position of a framing violation (-1 none); clr_at: symbol carrying
  // clr_cnt (-1 none); resync: the leading COM interrupts a partial set.
  task automatic send_set(input set_t s, input int bad, input bit gaps,
                          input int clr_at, input bit resync);
    logic [7:0] d; logic k;
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(7) == 0) idle($urandom_range(3, 1));
      if (i == bad) begin
        bad_sym(s, i, d, k);
        send_sym(d, k, 1'b0);
        model_err();
        return;
      end
      sym_of(s, i, d, k);
      send_sym(d, k, i == clr_at);
      if (i == 0 && resync) model_err();
      if (i == clr_at && i < 15) model_clear();
    end
    model_done(s, clr_at == 15);
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1; rxvalid = 1'b0;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    model_clear();
    chk("clr_ts1_cnt", 32'(ts1_cnt), 0);
    chk("clr_ts2_cnt", 32'(ts2_cnt), 0);
  endtask

  // Scoreboard monitor: every expected event must appear on exactly the
  // negedge following the edge it was scheduled for.
  always @(negedge clk) begin
    if (!reset) begin
      if (os_valid) begin
        vld_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_os_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("os_is_ts2",   32'(os_is_ts2),   32'(mon_e.s.ts2));
          chk("os_link",     32'(os_link),     32'(mon_e.s.link));
          chk("os_link_pad", 32'(os_link_pad), 32'(mon_e.s.lpad));
          chk("os_lane",     32'(os_lane),     32'(mon_e.s.lane));
          chk("os_lane_pad", 32'(os_lane_pad), 32'(mon_e.s.npad));
          chk("os_nfts",     32'(os_nfts),     32'(mon_e.s.nfts));
          chk("os_rate",     32'(os_rate),     32'(mon_e.s.rate));
          chk("os_ctrl",     32'(os_ctrl),     32'(mon_e.s.ctrl));
          chk("ts1_cnt",     32'(ts1_cnt),     32'(mon_e.c1));
          chk("ts2_cnt",     32'(ts2_cnt),     32'(mon_e.c2));
          chk("ts1_done",    32'(ts1_done),    32'(mon_e.c1 >= NTS));
          chk("ts2_done",    32'(ts2_done),    32'(mon_e.c2 >= NTS));
        end
      end else if (exp_q.size() != 0) begin
        tests++; fails++;
        $display("FAIL missing_os_valid: got 0 expected 1 (cycle %0d)", cyc);
        mon_e = exp_q.pop_front();
      end
      if (sym_err) begin
        if (err_seen >= err_pushed) begin
          tests++; fails++;
          $display("FAIL unexpected_sym_err: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          err_seen++;
          chk("err_ts1_cnt", 32'(ts1_cnt), 0);
          chk("err_ts2_cnt", 32'(ts2_cnt), 0);
        end
      end else if (err_seen < err_pushed) begin
        tests++; fails++;
        $display("FAIL missing_sym_err: got 0 expected 1 (cycle %0d)", cyc);
        err_seen++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_t s, a;
    int   n0, badsp, bad, clr_at;

    reset = 1'b1; en_n = 1'b0; clr_cnt = 1'b0;
    rxdata = 8'h00; rxdatak = 1'b0; rxvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_os_valid", 32'(os_valid), 0);
    chk("rst_sym_err",  32'(sym_err),  0);
    chk("rst_ts1_cnt",  32'(ts1_cnt),  0);
    chk("rst_ts2_cnt",  32'(ts2_cnt),  0);
    chk("rst_fields",   {os_link, os_lane, os_nfts, os_rate}, 0);
    chk("rst_flags",    32'({os_ctrl, os_is_ts2, os_link_pad, os_lane_pad, ts1_done, ts2_done}), 0);
    reset = 1'b0;
    idle(2);

    // 1024 back-to-back PAD/PAD TS1 sets
    s = mk(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    n0 = vld_cyc.size();
    for (int i = 0; i < NTS; i++) send_set(s, -1, 1'b0, -1, 1'b0);
    idle(1);
    badsp = 0;
    for (int i = n0 + 1; i < vld_cyc.size(); i++)
      if (vld_cyc[i] - vld_cyc[i-1] != 16) badsp++;
    chk("b2b_count",   32'(vld_cyc.size() - n0), NTS);
    chk("b2b_spacing", 32'(badsp), 0);
    chk("b2b_done",    32'(ts1_done), 1);

    // 8 TS1 then 1 TS2
    pulse_clr();
    s = mk(1'b0, 8'h02, 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) send_set(s, -1, 1'b0, -1, 1'b0);
    send_set(mk(1'b1, 8'h02, 1'b0, 8'h01, 1'b0), -1, 1'b0, -1, 1'b0);

    // Lane mismatch restarts the count
    send_set(mk(1'b0, 8'h02, 1'b0, 8'h03, 1'b0), -1, 1'b0, -1, 1'b0);
    s = mk(1'b0, 8'h02, 1'b0, 8'h04, 1'b0);
    send_set(s, -1, 1'b0, -1, 1'b0);

    // COM at symbol 9 of a TS1, then a full TS1 with no gap
    send_part(s, 0, 8);
    send_set(s, -1, 1'b0, -1, 1'b1);

    // rxvalid gap mid-set, then en_n mid-set
    send_part(s, 0, 7);
    idle(5);
    send_part(s, 8, 15);
    model_done(s, 1'b0);
    idle(1);
    send_part(s, 0, 7);
    en_n = 1'b1;
    for (int j = 0; j < 3; j++) send_sym(COM, 1'b1, 1'b0);
    model_clear();
    chk("enn_ts1_cnt",  32'(ts1_cnt),  0);
    chk("enn_ts2_cnt",  32'(ts2_cnt),  0);
    chk("enn_ts1_done", 32'(ts1_done), 0);
    en_n = 1'b0;
    send_part(s, 8, 15);
    send_set(s, -1, 1'b0, -1, 1'b0);

    // clr_cnt coinciding with symbol 15 wins over the update
    send_set(s, -1, 1'b0, 15, 1'b0);
    send_set(s, -1, 1'b0, -1, 1'b0);

    // Randomized traffic
    a = rnd_set();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(1) == 0) a = rnd_set();
      else begin
        a.nfts = 8'($urandom_range(255)); a.ctrl = 8'($urandom_range(255));
      end
      bad = ($urandom_range(5) == 0) ? $urandom_range(15, 1) : -1;
      clr_at = (bad < 0 && $urandom_range(9) == 0) ? $urandom_range(15) : -1;
      send_set(a, bad, 1'($urandom_range(1)), clr_at, 1'b0);
      if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
    end

    // ts1_cnt to 500, then asynchronous reset mid-set between edges
    pulse_clr();
    s = mk(1'b0, 8'h07, 1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 500; i++) send_set(s, -1, 1'b0, -1, 1'b0);
    idle(1);
    chk("pre_rst_ts1_cnt", 32'(ts1_cnt), 500);
    send_part(s, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ts1_cnt", 32'(ts1_cnt), 0);
    chk("arst_os",      32'({os_valid, os_is_ts2, os_link, os_lane, os_link_pad, os_lane_pad}), 0);
    chk("arst_os2",     32'({os_nfts, os_rate, os_ctrl, sym_err, ts1_done, ts2_done}), 0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    send_part(s, 6, 15);
    send_set(s, -1, 1'b0, -1, 1'b0);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("sym_err_total",      32'(err_seen), 32'(err_pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
